// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed N-digit common-anode seven-segment driver.
// Double-buffers the display data so new values only take effect at frame boundaries,
// blanks the first GAP cycles of every digit slot to avoid ghosting, and can suppress
// leading zeros. All outputs decode from registered state only.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int GAP        = 16,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  output logic [6:0]              segment_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [IDX_W-1:0]        digit_idx_o,
  output logic                    frame_o
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] pend_value, active_value;
  logic [NUM_DIGITS-1:0]   pend_dp, active_dp;
  logic                    pend_valid;
  logic                    blank_lz_q;

  // Active-low hex segment table, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = 7'b0000001;
      4'h1: seg_code = 7'b1001111;
      4'h2: seg_code = 7'b0010010;
      4'h3: seg_code = 7'b0000110;
      4'h4: seg_code = 7'b1001100;
      4'h5: seg_code = 7'b0100100;
      4'h6: seg_code = 7'b0100000;
      4'h7: seg_code = 7'b0001111;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0001100;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b1100000;
      4'hC: seg_code = 7'b0110001;
      4'hD: seg_code = 7'b1000010;
      4'hE: seg_code = 7'b0110000;
      default: seg_code = 7'b0111000;
    endcase
  endfunction

  // State, slot counter and digit index registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; commit marks the IDLE->SCAN edge and the frame-boundary wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = '0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = SCAN;
          commit  = 1'b1;
        end
      end
      SCAN: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          if (idx_q == LAST_IDX) begin
            commit = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q;
        end
      end
    endcase
  end

  // Pending/active double buffer; a load coinciding with a commit bypasses into active.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_value   <= '0;
      pend_dp      <= '0;
      pend_valid   <= 1'b0;
      active_value <= '0;
      active_dp    <= '0;
      blank_lz_q   <= 1'b0;
    end else begin
      blank_lz_q <= blank_lz_i;
      if (load_i) begin
        pend_value <= value_i;
        pend_dp    <= dp_i;
      end
      if (commit) begin
        pend_valid <= 1'b0;
        if (load_i) begin
          active_value <= value_i;
          active_dp    <= dp_i;
        end else if (pend_valid) begin
          active_value <= pend_value;
          active_dp    <= pend_dp;
        end
      end else if (load_i) begin
        pend_valid <= 1'b1;
      end
    end
  end

  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  zero_above;
  logic                  lz_blank;
  logic                  gap_phase;
  logic [NUM_DIGITS-1:0] sel;

  // Output decode from registered state: digit select, segment code, gap and zero blanking.
  always_comb begin
    nib        = 4'h0;
    dp_bit     = 1'b0;
    zero_above = 1'b1;
    lz_blank   = 1'b0;
    sel        = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (active_value[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib      = active_value[4*i +: 4];
        dp_bit   = active_dp[i];
        lz_blank = blank_lz_q && zero_above && (i != 0);
        sel[i]   = 1'b0;
      end
    end
    gap_phase   = int'(cnt_q) < GAP;
    segment_o   = 7'b1111111;
    dp_o        = 1'b1;
    anode_o     = '1;
    digit_idx_o = idx_q;
    frame_o     = 1'b0;
    if (state_q == SCAN) begin
      frame_o = (idx_q == LAST_IDX) && (cnt_q == LAST_CNT);
      if (!gap_phase) begin
        anode_o   = sel;
        segment_o = lz_blank ? 7'b1111111 : seg_code(nib);
        dp_o      = ~dp_bit;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed testbench for seven_segment_scanner with NUM_DIGITS=4, PRESCALE=8, GAP=1.
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int GP = 1;

  logic        clk = 1'b0;
  logic        reset_i, enable_i, load_i, blank_lz_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [6:0]  segment_o;
  logic        dp_o;
  logic [3:0]  anode_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;

  seven_segment_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS), .GAP(GP)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .load_i(load_i),
    .value_i(value_i), .dp_i(dp_i), .blank_lz_i(blank_lz_i),
    .segment_o(segment_o), .dp_o(dp_o), .anode_o(anode_o),
    .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    value_i = v;
    dp_i    = d;
    load_i  = 1'b1;
    step(1);
    load_i  = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_o !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    check("frame_wait", 32'(frame_o), 32'd1);
  endtask

  // Starts at digit 0 counter 0; checks gap and lit segments of each digit.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_d%0d_gap_anode", tag, d), 32'(anode_o), 32'hF);
      step(1);
      check($sformatf("%s_d%0d_idx", tag, d), 32'(digit_idx_o), 32'(d));
      check($sformatf("%s_d%0d_seg", tag, d), 32'(segment_o), 32'(s[d]));
      step(7);
    end
  endtask

  logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
  logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int fc;
    reset_i = 1'b0; enable_i = 1'b0; load_i = 1'b0; blank_lz_i = 1'b0;
    value_i = '0; dp_i = '0;
    #2 reset_i = 1'b1;
    step(1);
    check("rst_anode", 32'(anode_o), 32'hF);
    check("rst_seg", 32'(segment_o), 32'h7F);
    check("rst_dp", 32'(dp_o), 32'd1);
    check("rst_idx", 32'(digit_idx_o), 32'd0);
    check("rst_frame", 32'(frame_o), 32'd0);
    reset_i = 1'b0;
    step(1);

    // 12AF with dp on digit 2
    load(16'h12AF, 4'b0100);
    enable_i = 1'b1;
    step(1);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("hex_d%0d_gap_anode", d), 32'(anode_o), 32'hF);
      step(1);
      check($sformatf("hex_d%0d_anode", d), 32'(anode_o), 32'(exp_an[d]));
      check($sformatf("hex_d%0d_seg", d), 32'(segment_o), 32'(exp_seg[d]));
      check($sformatf("hex_d%0d_dp", d), 32'(dp_o), 32'(exp_dp[d]));
      step(6);
      check($sformatf("hex_d%0d_frame", d), 32'(frame_o), (d == 3) ? 32'd1 : 32'd0);
      step(1);
    end
    fc = 0;
    repeat (32) begin
      if (frame_o === 1'b1) fc++;
      step(1);
    end
    check("frame_count", 32'(fc), 32'd1);

    // leading-zero suppression
    blank_lz_i = 1'b1;
    load(16'h0050, 4'b0000);
    wait_frame();
    step(1);
    check_frame("lz0050", 7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111);
    load(16'h0000, 4'b0000);
    wait_frame();
    step(1);
    check_frame("lz0000", 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111);
    blank_lz_i = 1'b0;

    // load during digit-1 slot does not tear the current frame
    load(16'h1234, 4'b0000);
    wait_frame();
    step(1);
    step(10);
    load(16'h9999, 4'b0000);
    step(5);
    step(1);
    check("tear_d2_seg", 32'(segment_o), 32'(7'b0010010));
    step(7);
    step(1);
    check("tear_d3_seg", 32'(segment_o), 32'(7'b1001111));
    step(7);
    check_frame("nines", 7'b0001100, 7'b0001100, 7'b0001100, 7'b0001100);

    // load on the frame-boundary edge bypasses into active
    wait_frame();
    value_i = 16'hBEEF;
    dp_i    = 4'b0000;
    load_i  = 1'b1;
    step(1);
    load_i  = 1'b0;
    check("bypass_pend_valid", 32'(dut.pend_valid), 32'd0);
    check_frame("beef", 7'b0111000, 7'b0110000, 7'b0110000, 7'b1100000);

    // enable drop mid-slot at digit 1
    step(11);
    check("en_pre_idx", 32'(digit_idx_o), 32'd1);
    enable_i = 1'b0;
    step(1);
    check("en_off_anode", 32'(anode_o), 32'hF);
    check("en_off_idx", 32'(digit_idx_o), 32'd0);
    check("en_off_seg", 32'(segment_o), 32'h7F);
    step(2);
    check("en_idle_idx", 32'(digit_idx_o), 32'd0);
    enable_i = 1'b1;
    step(1);
    check("en_resume_idx", 32'(digit_idx_o), 32'd0);
    check("en_resume_gap", 32'(anode_o), 32'hF);
    step(1);
    check("en_resume_anode", 32'(anode_o), 32'hE);
    check("en_resume_seg", 32'(segment_o), 32'(7'b0111000));
    step(6);
    step(1);
    check("en_next_idx", 32'(digit_idx_o), 32'd1);

    // asynchronous reset at digit 2 counter 5
    step(13);
    check("rst_mid_pre_anode", 32'(anode_o), 32'hB);
    #1 reset_i = 1'b1;
    #1;
    check("rst_mid_anode", 32'(anode_o), 32'hF);
    check("rst_mid_seg", 32'(segment_o), 32'h7F);
    check("rst_mid_dp", 32'(dp_o), 32'd1);
    check("rst_mid_idx", 32'(digit_idx_o), 32'd0);
    step(1);
    reset_i = 1'b0;
    step(1);
    check("rst_restart_idx", 32'(digit_idx_o), 32'd0);
    check("rst_restart_gap", 32'(anode_o), 32'hF);
    step(1);
    check("rst_restart_anode", 32'(anode_o), 32'hE);
    check("rst_restart_seg", 32'(segment_o), 32'(7'b0000001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for an N-digit common-anode seven-segment display; it is the parametrised successor to the single-digit hex decoder. The block double-buffers a packed hex value and decimal points, and commits new data only at frame boundaries so the display never tears. It scans one digit per refresh slot with an anti-ghosting blank gap at the start of each slot, and optionally suppresses leading zeros. It sits between the voltmeter datapath and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, digits scanned (1..8); digit 0 = least significant
- PRESCALE, 1000, clock cycles per digit slot (>= 2)
- GAP, 16, blank cycles at the start of each slot (0 <= GAP < PRESCALE)
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous, active-high reset
- enable_i  input  1  scan enable; low = display dark
- load_i  input  1  one-cycle strobe; captures value_i/dp_i into the pending buffer
- value_i  input  4*NUM_DIGITS  packed hex nibbles; digit i = value_i[4i+3:4i]
- dp_i  input  NUM_DIGITS  decimal-point request per digit, 1 = lit
- blank_lz_i  input  1  leading-zero suppression enable
- segment_o  output  7  active-low segments; bit 6 = a … bit 0 = g
- dp_o  output  1  active-low decimal point
- anode_o  output  NUM_DIGITS  active-low digit select, one-hot-low or all ones
- digit_idx_o  output  max(1,$clog2(NUM_DIGITS))  digit currently being scanned
- frame_o  output  1  pulses high on the last cycle of each frame

## Operation
- The segment code table is the team's standard active-low hex set: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. Blank is 1111111.
- Buffers:
  - pending {value, dp, valid} is written on load_i and sets valid.
  - active {value, dp} drives the display.
  - A commit copies pending into active and clears valid. It occurs only on a frame-boundary edge or an IDLE→SCAN edge.
  - If load_i is asserted on a commit edge, value_i/dp_i bypass directly into active and valid ends clear.
- FSM:
  - IDLE: anodes off, counters held at 0. Moves to SCAN when enable_i=1, committing pending if valid.
  - SCAN: the prescale counter counts 0..PRESCALE-1. On wrap, digit_idx increments modulo NUM_DIGITS. The wrap from NUM_DIGITS-1 to 0 is the frame-boundary edge.
  - enable_i=0 in SCAN returns the FSM to IDLE on the next edge, regardless of slot position.
- Per slot, while counter < GAP:
  - anode_o is all ones.
  - segment_o is 1111111.
  - dp_o is 1.
- Per slot, while counter >= GAP:
  - anode_o[digit_idx] is 0; all other anodes are 1.
  - segment_o is the code for the active nibble.
  - dp_o is ~active_dp[digit_idx].
- Leading-zero suppression, when blank_lz_i=1:
  - Digit i is blanked when its nibble and all higher nibbles are 0; dp follows active_dp even when the digit is blanked.
  - Digit 0 is never suppressed.
- frame_o = SCAN && digit_idx==NUM_DIGITS-1 && counter==PRESCALE-1.

## Timing
- Reset, asynchronous:
  - segment_o=1111111, dp_o=1, anode_o=all ones.
  - digit_idx_o=0, frame_o=0.
  - Counter is 0 and the FSM is in IDLE.
  - Both buffers are 0 and pending valid is 0.
- All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.
- IDLE→SCAN edge:
  - The first SCAN cycle is slot digit 0, counter 0.
  - Segments appear GAP cycles later.
- Frame period is NUM_DIGITS*PRESCALE cycles. Load-to-display latency is at most one frame plus GAP cycles.
- A load mid-frame leaves the remaining slots of the current frame showing the old data.
- Multiple loads before a commit: the last one wins.
- Reset mid-slot forces the reset values immediately; scanning restarts from digit 0 once reset is released and enable_i=1.
- GAP=0: no blank cycles; the anode is active for the whole slot.

## Test plan
- Reset during SCAN at digit 2, counter 5 → anode_o=1111, segment_o=1111111, dp_o=1 immediately. After release with enable_i=1, scanning restarts at digit_idx_o=0.
- NUM_DIGITS=4, PRESCALE=8, GAP=1, load 16'h12AF, dp_i=4'b0100, then enable → the display shows, in order:
  - Digit 0: anode_o=1110, segment_o=0111000.
  - Digit 1: anode_o=1101, segment_o=0001000.
  - Digit 2: anode_o=1011, segment_o=0010010, dp_o=0.
  - Digit 3: anode_o=0111, segment_o=1001111.
  - Cycle 0 of every slot shows anode_o=1111.
- blank_lz_i=1:
  - value 16'h0050 → digits 3 and 2 show 1111111, digit 1 shows 0100100, digit 0 shows 0000001.
  - value 16'h0000 → only digit 0 is lit, showing 0000001.
- Load 16'h9999 during the digit-1 slot of a frame displaying 16'h1234 → digits 2 and 3 of this frame show 2 and 1. The next frame shows 9 on all digits. frame_o is high for exactly 1 cycle per 32.
- load_i on the frame-boundary edge with 16'hBEEF → the next digit-0 slot shows F (0111000) and pending valid is 0.
- enable_i drops mid-slot at digit 1 → the next edge gives anode_o=1111 and digit_idx_o=0. Re-enable → scanning resumes at digit 0, counter 0.
